// File: rtl/vga_sync_decoder_if.sv
// Incoming VGA stream: active-low sync pulses plus per-colour pixel data,
// all synchronous to the pixel clock.
//   hsync, vsync    : active-low sync pulses
//   red, grn, blu   : pixel data, VIDEO_WIDTH bits each
// master drives the stream (generator / link), slave consumes it (decoder).
interface vga_sync_decoder_if #(
  parameter int VIDEO_WIDTH = 3
);
  logic                   hsync;
  logic                   vsync;
  logic [VIDEO_WIDTH-1:0] red;
  logic [VIDEO_WIDTH-1:0] grn;
  logic [VIDEO_WIDTH-1:0] blu;

  modport master (output hsync, vsync, red, grn, blu);
  modport slave  (input  hsync, vsync, red, grn, blu);
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery. Rebuilds column/row position from the
// sync rising edges, measures line length and lines per frame against the
// configured totals, and declares lock after LOCK_FRAMES good frames.
//   i_Clk, i_Rst_L        : pixel clock, async active-low reset
//   vid                   : incoming sync + pixel stream (slave modport)
//   o_Col_Count/o_Row_Count: recovered position of the pixel just sampled
//   o_*_Video             : pixel data, zeroed outside the active region
//   o_Active              : locked and inside the visible area
//   o_Frame_Start         : one-cycle pulse at (0,0) while locked
//   o_Locked, o_Err       : timing lock and one-cycle violation pulse
module vga_sync_decoder #(
  parameter int TOTAL_COLS   = 800,
  parameter int TOTAL_ROWS   = 525,
  parameter int ACTIVE_COLS  = 640,
  parameter int ACTIVE_ROWS  = 480,
  parameter int H_BACK_PORCH = 48,
  parameter int V_BACK_PORCH = 33,
  parameter int LOCK_FRAMES  = 2,
  parameter int VIDEO_WIDTH  = 3
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  vga_sync_decoder_if.slave      vid,
  output logic [9:0]             o_Col_Count,
  output logic [9:0]             o_Row_Count,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Active,
  output logic                   o_Frame_Start,
  output logic                   o_Locked,
  output logic                   o_Err
);
  localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0]    COL_LAST  = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]    ROW_LAST  = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0]    COL_LOAD  = 10'(TOTAL_COLS - H_BACK_PORCH);
  localparam logic [9:0]    ROW_LOAD  = 10'(TOTAL_ROWS - V_BACK_PORCH);
  localparam logic [9:0]    COL_ACT   = 10'(ACTIVE_COLS);
  localparam logic [9:0]    ROW_ACT   = 10'(ACTIVE_ROWS);
  localparam logic [10:0]   LEN_GOOD  = 11'(TOTAL_COLS);
  localparam logic [10:0]   LEN_SAT   = 11'(2 * TOTAL_COLS);
  localparam logic [9:0]    ROWS_GOOD = 10'(TOTAL_ROWS);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);
  localparam logic [GW-1:0] GOOD_ONE  = GW'(1);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

  state_t          state, state_nx;
  logic            prev_hsync, prev_vsync;
  logic [9:0]      col, row, col_nx, row_nx;
  logic [10:0]     line_len, len_nx;
  logic [9:0]      line_cnt, cnt_nx;
  logic            hlen_valid, vlen_valid, frame_err;
  logic [GW-1:0]   good_frames, good_nx;
  logic            h_rise, v_rise, col_wrap;
  logic            err_h, err_v, err_sat, err, frame_good;
  logic            lock_nx, active_nx;

  always_comb begin
    h_rise   = ~prev_hsync & vid.hsync;
    v_rise   = ~prev_vsync & vid.vsync;
    // A sync-driven column load is not a wrap, so it never advances the row.
    col_wrap = ~h_rise & (col == COL_LAST);

    if (h_rise)        col_nx = COL_LOAD;
    else if (col_wrap) col_nx = '0;
    else               col_nx = col + 10'd1;

    if (v_rise)        row_nx = ROW_LOAD;
    else if (col_wrap) row_nx = (row == ROW_LAST) ? '0 : row + 10'd1;
    else               row_nx = row;

    // line_len holds clocks-since-rise minus one at the next rise edge.
    err_h   = h_rise & hlen_valid & ((line_len + 11'd1) != LEN_GOOD);
    err_sat = ~h_rise & (line_len == (LEN_SAT - 11'd1));
    err_v   = v_rise & vlen_valid & (line_cnt != ROWS_GOOD);
    err     = err_h | err_v | err_sat;

    if (h_rise)                  len_nx = '0;
    else if (line_len == LEN_SAT) len_nx = LEN_SAT;
    else                         len_nx = line_len + 11'd1;

    // A coincident HSync rise belongs to the frame that starts on this edge.
    if (v_rise)                        cnt_nx = {9'd0, h_rise};
    else if (h_rise && line_cnt != '1) cnt_nx = line_cnt + 10'd1;
    else                               cnt_nx = line_cnt;

    frame_good = v_rise & vlen_valid & ~frame_err & ~err;

    state_nx = state;
    good_nx  = good_frames;
    if (err) begin
      state_nx = UNLOCKED;
      good_nx  = '0;
    end else if (v_rise) begin
      case (state)
        UNLOCKED: if (frame_good) begin
          good_nx  = GOOD_ONE;
          state_nx = (GOOD_LOCK == GOOD_ONE) ? LOCKED : CHECK;
        end
        CHECK: if (frame_good) begin
          good_nx = good_frames + GOOD_ONE;
          if ((good_frames + GOOD_ONE) == GOOD_LOCK) state_nx = LOCKED;
        end else begin
          state_nx = UNLOCKED;
          good_nx  = '0;
        end
        LOCKED:  state_nx = LOCKED;
        default: begin
          state_nx = UNLOCKED;
          good_nx  = '0;
        end
      endcase
    end

    lock_nx   = (state_nx == LOCKED);
    active_nx = lock_nx & (col_nx < COL_ACT) & (row_nx < ROW_ACT);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= UNLOCKED;
      prev_hsync    <= 1'b1;
      prev_vsync    <= 1'b1;
      col           <= '0;
      row           <= '0;
      line_len      <= '0;
      line_cnt      <= '0;
      hlen_valid    <= 1'b0;
      vlen_valid    <= 1'b0;
      frame_err     <= 1'b0;
      good_frames   <= '0;
      o_Red_Video   <= '0;
      o_Grn_Video   <= '0;
      o_Blu_Video   <= '0;
      o_Active      <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Locked      <= 1'b0;
      o_Err         <= 1'b0;
    end else begin
      state         <= state_nx;
      prev_hsync    <= vid.hsync;
      prev_vsync    <= vid.vsync;
      col           <= col_nx;
      row           <= row_nx;
      line_len      <= len_nx;
      line_cnt      <= cnt_nx;
      // Losing HSync invalidates both measurements until fresh rises arrive.
      hlen_valid    <= ~err_sat & (h_rise | hlen_valid);
      vlen_valid    <= ~err_sat & (v_rise | vlen_valid);
      frame_err     <= ~v_rise & (frame_err | err);
      good_frames   <= good_nx;
      o_Red_Video   <= active_nx ? vid.red : '0;
      o_Grn_Video   <= active_nx ? vid.grn : '0;
      o_Blu_Video   <= active_nx ? vid.blu : '0;
      o_Active      <= active_nx;
      o_Frame_Start <= lock_nx & (col_nx == '0) & (row_nx == '0);
      o_Locked      <= lock_nx;
      o_Err         <= err;
    end
  end

  assign o_Col_Count = col;
  assign o_Row_Count = row;
endmodule
